vga_mem_arbiter: RTL

- Round-robin arbiter that shares one synchronous single-port register/memory array between NUM_REQ native requesters.
- Requester 0 is the AXI-Lite slave FSM native side (via a thin adapter); others are internal VGA engines such as the timing and fetch units.
- Accepts at most one request per cycle, drives the memory port registered, and routes each response to the requester that issued it.

---
 rtl/vga_axil_pkg.sv | 31 +++
 rtl/vga_rr_arbiter.sv | 48 ++++
 rtl/vga_mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_axil_pkg.sv
// Shared types for the VGA register block: AXI-Lite data, native addressing and
// the memory-arbiter request/pipeline types.
package vga_axil_pkg;

    localparam int AXIL_DATA_WIDTH   = 32;
    localparam int NATIVE_ADDR_WIDTH = 10;
    localparam int VGA_NUM_REQ       = 2;

    typedef logic [AXIL_DATA_WIDTH-1:0]   axil_data_t;
    typedef logic [NATIVE_ADDR_WIDTH-1:0] native_addr_t;
    typedef logic [$clog2(VGA_NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic         we;
        native_addr_t addr;
        axil_data_t   wdata;
    } mem_op_t;

    // ISSUE and RESP can be live together when accesses are back to back.
    typedef enum logic [1:0] {
        PIPE_EMPTY,
        PIPE_ISSUE,
        PIPE_RESP,
        PIPE_ISSUE_RESP
    } pipe_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_rr_arbiter.sv
// Round-robin grant generator: one-hot grant from the request vector, searching
// upward from the requester after the last winner.
module vga_rr_arbiter
    import vga_axil_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W   = id_width(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                advance_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ID_W-1:0]     grant_id_o
);

    logic [ID_W-1:0] last_grant_q;
    logic [ID_W-1:0] last_grant_d;
    logic            found;

    // The double loop keeps every bit select on a loop constant.
    always_comb begin
        grant_o    = '0;
        grant_id_o = last_grant_q;
        found      = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_i[i] && (i == (int'(last_grant_q) + off) % NUM_REQ)) begin
                    found      = 1'b1;
                    grant_o[i] = 1'b1;
                    grant_id_o = ID_W'(i);
                end
            end
        end
    end

    assign last_grant_d = advance_i ? grant_id_o : last_grant_q;

    // Reset points at the highest id so requester 0 wins the first contest.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares one synchronous single-port memory between NUM_REQ native requesters,
// with registered memory outputs and in-order responses two cycles after accept.
module vga_mem_arbiter
    import vga_axil_pkg::*;
#(
    parameter int NUM_REQ    = VGA_NUM_REQ,
    parameter int ADDR_WIDTH = NATIVE_ADDR_WIDTH,
    parameter int DATA_WIDTH = AXIL_DATA_WIDTH
) (
    input  logic                                clk_i,
    input  logic                                arst_i,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  logic [NUM_REQ-1:0]                  req_write_i,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata_i,
    output logic [NUM_REQ-1:0]                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
    output logic                                mem_en_o,
    output logic                                mem_we_o,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]               mem_rdata_i
);

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic                  handshake;

    logic                  mem_en_q,    mem_en_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [ID_W-1:0]       iss_id_q,    iss_id_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_we_q,    rsp_we_d;
    logic [ID_W-1:0]       rsp_id_q,    rsp_id_d;

    pipe_state_t           pipe_state;
    logic                  rsp_active;

    vga_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .req_i      (req_valid_i),
        .advance_i  (handshake),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign req_ready_o = arst_i ? '0 : grant;
    assign handshake   = |(req_valid_i & req_ready_o);

    // Address/wdata only load on an accept; idle cycles just drop the enables.
    always_comb begin
        mem_en_d    = handshake;
        mem_we_d    = handshake & req_write_i[grant_id];
        mem_addr_d  = handshake ? req_addr_i[grant_id]  : mem_addr_q;
        mem_wdata_d = handshake ? req_wdata_i[grant_id] : mem_wdata_q;
        iss_id_d    = grant_id;
        rsp_valid_d = mem_en_q;
        rsp_we_d    = mem_we_q;
        rsp_id_d    = iss_id_q;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            iss_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            iss_id_q    <= iss_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    always_comb begin
        case ({mem_en_q, rsp_valid_q})
            2'b00:   pipe_state = PIPE_EMPTY;
            2'b10:   pipe_state = PIPE_ISSUE;
            2'b01:   pipe_state = PIPE_RESP;
            default: pipe_state = PIPE_ISSUE_RESP;
        endcase
    end

    assign rsp_active = (pipe_state == PIPE_RESP) || (pipe_state == PIPE_ISSUE_RESP);

    // Memory read data lines up with the response stage; writes ack with zero.
    always_comb begin
        rsp_valid_o = '0;
        if (rsp_active) begin
            rsp_valid_o[rsp_id_q] = 1'b1;
        end
        rsp_rdata_o = (rsp_active && !rsp_we_q) ? mem_rdata_i : '0;
    end

    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
